// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep controller and DDS core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

    localparam int KW_DEF = 32;  // frequency-word width (phase accumulator)
    localparam int PW_DEF = 11;  // phase-offset width (ROM address)
    localparam int DW_DEF = 16;  // dwell-counter width

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host/config and DDS-facing signal bundle for dds_sweep_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; start is a pulse, abort a level or pulse.
// master: host side (drives start/abort/cfg_*, observes K/P/status).
// slave : sweep controller (consumes start/abort/cfg_*, drives K/P/status).
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int KW = KW_DEF,
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF
);
    logic          start;
    logic          abort;
    logic [KW-1:0] cfg_k_start;
    logic [KW-1:0] cfg_k_stop;
    logic [KW-1:0] cfg_k_step;
    logic [DW-1:0] cfg_dwell;
    logic [PW-1:0] cfg_phase;
    logic          cfg_loop;
    logic [KW-1:0] K;
    logic [PW-1:0] P;
    logic          busy;
    logic          done;
    logic          wrap;
    logic          err;

    modport master (
        output start, abort, cfg_k_start, cfg_k_stop, cfg_k_step,
               cfg_dwell, cfg_phase, cfg_loop,
        input  K, P, busy, done, wrap, err
    );

    modport slave (
        input  start, abort, cfg_k_start, cfg_k_stop, cfg_k_step,
               cfg_dwell, cfg_phase, cfg_loop,
        output K, P, busy, done, wrap, err
    );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that times how long each sweep point is held.
// Latency: load/decrement take effect on the next edge; zero is combinational from the count.
// Backpressure: none; en stalls counting, count saturates at zero.
// Ports: clk, rst_n, load (priority), en, load_val, zero (count == 0).
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] load_val,
    output logic          zero
);

    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving K (frequency word) and P (phase) into the DDS core.
// Latency: K = start word the cycle after start is sampled; each point held dwell+1 cycles.
// Backpressure: none; start ignored while busy, abort wins over start and end-of-sweep.
// Ports: clk, rst_n (async, active low), sif (dds_sweep_ctrl_if.slave: start/abort/cfg_* in,
//        K/P/busy/done/wrap/err out).
// Build option: DDS_SWEEP_DOWN_EN allows start > stop as a down-sweep (adds a subtractor);
//        without it start > stop is a config error.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int KW = KW_DEF,
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    dds_sweep_ctrl_if.slave    sif
);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [PW-1:0] p_q, p_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;

    // Configuration captured at start; live cfg_* is ignored while running.
    logic [KW-1:0] k_start_q, k_start_d;
    logic [KW-1:0] k_stop_q, k_stop_d;
    logic [KW-1:0] k_step_q, k_step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          loop_q, loop_d;

    logic          tmr_load;
    logic          tmr_en;
    logic [DW-1:0] tmr_val;
    logic          tmr_zero;

    logic          cfg_bad;
    logic [KW:0]   next_up;
    logic          up_ok;
    logic [KW-1:0] next_k;
    logic          step_ok;

`ifdef DDS_SWEEP_DOWN_EN
    logic          down_q, down_d;
    logic [KW:0]   next_dn;
    logic          dn_ok;
`endif

    dds_dwell_timer #(.DW(DW)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next point computed one bit wider so a carry (or borrow) past the
    // word width ends the sweep instead of wrapping to a low frequency.
    always_comb begin
        next_up = {1'b0, k_q} + {1'b0, k_step_q};
        up_ok   = !next_up[KW] && (next_up[KW-1:0] <= k_stop_q);
`ifdef DDS_SWEEP_DOWN_EN
        next_dn = {1'b0, k_q} - {1'b0, k_step_q};
        dn_ok   = !next_dn[KW] && (next_dn[KW-1:0] >= k_stop_q);
        next_k  = down_q ? next_dn[KW-1:0] : next_up[KW-1:0];
        step_ok = down_q ? dn_ok : up_ok;
`else
        next_k  = next_up[KW-1:0];
        step_ok = up_ok;
`endif
    end

    always_comb begin
        cfg_bad = (sif.cfg_k_step == '0);
`ifndef DDS_SWEEP_DOWN_EN
        cfg_bad = cfg_bad || (sif.cfg_k_start > sif.cfg_k_stop);
`endif
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        p_d       = p_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        err_d     = err_q;
        k_start_d = k_start_q;
        k_stop_d  = k_stop_q;
        k_step_d  = k_step_q;
        dwell_d   = dwell_q;
        loop_d    = loop_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = dwell_q;
`ifdef DDS_SWEEP_DOWN_EN
        down_d    = down_q;
`endif

        case (state_q)
            IDLE: begin
                if (sif.start && !sif.abort) begin
                    k_start_d = sif.cfg_k_start;
                    k_stop_d  = sif.cfg_k_stop;
                    k_step_d  = sif.cfg_k_step;
                    dwell_d   = sif.cfg_dwell;
                    loop_d    = sif.cfg_loop;
`ifdef DDS_SWEEP_DOWN_EN
                    down_d    = (sif.cfg_k_start > sif.cfg_k_stop);
`endif
                    if (cfg_bad) begin
                        // Rejected start still completes the handshake with done.
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        k_d      = sif.cfg_k_start;
                        p_d      = sif.cfg_phase;
                        busy_d   = 1'b1;
                        err_d    = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = sif.cfg_dwell;
                        state_d  = RUN;
                    end
                end
            end

            RUN: begin
                if (sif.abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (tmr_zero) begin
                    if (step_ok) begin
                        k_d      = next_k;
                        tmr_load = 1'b1;
                    end else if (loop_q) begin
                        k_d      = k_start_q;
                        wrap_d   = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        // K keeps the last on-grid point.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            p_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            k_start_q <= '0;
            k_stop_q  <= '0;
            k_step_q  <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
`ifdef DDS_SWEEP_DOWN_EN
            down_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            p_q       <= p_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
            k_start_q <= k_start_d;
            k_stop_q  <= k_stop_d;
            k_step_q  <= k_step_d;
            dwell_q   <= dwell_d;
            loop_q    <= loop_d;
`ifdef DDS_SWEEP_DOWN_EN
            down_q    <= down_d;
`endif
        end
    end

    assign sif.K    = k_q;
    assign sif.P    = p_q;
    assign sif.busy = busy_q;
    assign sif.done = done_q;
    assign sif.wrap = wrap_q;
    assign sif.err  = err_q;

endmodule
